mult_div_unit: RTL and testbench

//   Iterative 32-bit multiply/divide unit in the EX stage, downstream of the

---
 rtl/mult_div_unit.sv | 131 +++++++++++++
 tb/tb_mult_div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit feeding the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle on magnitudes, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m, r_p, r_q, r_hi, r_lo;
  logic             r_neg_q, r_neg_r, r_dz, r_done;

  // op[0]==0 selects the signed variants.
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_shift, w_diff;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_a_neg = ~op[0] & rs_data[WIDTH-1];
  assign w_b_neg = ~op[0] & rt_data[WIDTH-1];
  assign w_a_mag = w_a_neg ? -rs_data : rs_data;
  assign w_b_mag = w_b_neg ? -rt_data : rt_data;

  assign w_sum   = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_shift = {r_p, r_q[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_m};

  // With a zero divisor the remainder path ends holding |dividend|, so the
  // ordinary sign fix already restores rs_data into HI; only LO is forced.
  assign w_prod     = {r_p, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo      = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
  assign w_rem      = r_neg_r ? -r_p : r_p;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (r_cnt == CW'(WIDTH - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    done        = r_done;
    hi          = r_hi;
    lo          = r_lo;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op    <= '0;
      r_cnt   <= '0;
      r_m     <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_cnt   <= '0;
            r_p     <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= op[1] & (rt_data == '0);
            r_m     <= op[1] ? w_b_mag : w_a_mag;
            r_q     <= op[1] ? w_a_mag : w_b_mag;
          end else begin
            if (hi_we) r_hi <= rs_data;
            if (lo_we) r_lo <= rs_data;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_op[1]) begin
            r_p <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
            r_q <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
          end else begin
            r_p <= w_sum[WIDTH:1];
            r_q <= {w_sum[0], r_q[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          r_done <= 1'b1;
          if (r_op[1]) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed corner cases plus random ops, results
// checked through an expected-value queue against an independent arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, done;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  logic [63:0]  exp_q[$];
  logic [63:0]  last_hilo;
  int           n_checks = 0;
  int           n_errors = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .o_dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic signed [63:0] xa, xb;
    sa = a; sb = b;
    xa = sa; xb = sb;
    case (o)
      2'b00: return xa * xb;
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        sq = sa / sb; sr = sa % sb;
        return {sr, sq};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // scoreboard: compare on every done pulse
  always @(negedge clk) begin : sb_mon
    logic [63:0] e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else begin
        e = exp_q.pop_front();
        check("result", {hi, lo}, e);
      end
    end
  end

  // Launch one op and follow it to done. b2b: drive immediately (caller is at
  // the negedge where done is high). disturb: poke start/we/operands mid-op.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit b2b, input bit disturb, input bit with_lo_we);
    int edges, busy_cnt;
    logic [63:0] prev;
    if (!b2b) @(negedge clk);
    prev = last_hilo;
    start = 1'b1; op = o; rs_data = a; rt_data = b; lo_we = with_lo_we;
    exp_q.push_back(model(o, a, b));
    last_hilo = model(o, a, b);
    @(posedge clk);
    edges = 1; busy_cnt = 0;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    rs_data = $urandom; rt_data = $urandom;
    while (done !== 1'b1 && edges < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (busy_cnt == 6) check("hold", {hi, lo}, prev);
      if (disturb && busy_cnt == 5) begin
        start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
        op = $urandom_range(0, 3); rs_data = $urandom; rt_data = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      @(posedge clk); edges++;
      @(negedge clk);
    end
    check("latency", 64'(edges), 64'd34);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; rs_data = '0; rt_data = '0; last_hilo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    run_op(2'b00, -32'sd7, 32'd3, 0, 0, 0);
    run_op(2'b10, -32'sd7, 32'd2, 1, 0, 0);
    run_op(2'b11, 32'd100, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    run_op(2'b00, 32'h80000000, 32'h80000000, 0, 0, 0);
    run_op(2'b10, -32'sd7, 32'd0, 0, 0, 0);
    run_op(2'b10, 32'd7, -32'sd2, 0, 0, 0);
    run_op(2'b11, 32'd10, 32'd3, 0, 1, 0);

    // reset in the middle of an op
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd12345; rt_data = 32'd6789;
    exp_q.push_back(model(2'b01, 32'd12345, 32'd6789));
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0; last_hilo = '0;
    run_op(2'b00, 32'd1000, -32'sd3, 0, 0, 0);

    // mthi + mtlo together
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; rs_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'h12345678, 32'h12345678});
    last_hilo = {32'h12345678, 32'h12345678};

    // start wins over a simultaneous mtlo
    run_op(2'b01, 32'd6, 32'd7, 0, 0, 1);

    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
